// File: rtl/data_mem_responder.sv
// Load/store responder in front of a little-endian byte-addressed data RAM.
// It handles one request at a time: IDLE accepts it, WAIT runs the wait states, and RESP holds the response until the requester takes it.
module data_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [2:0]            bytecontrol,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            bc_q, bc_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  capture;
    logic                  commit;

    logic [7:0] mem_q [DEPTH];

    function automatic logic access_err(input logic we, input logic [1:0] off,
                                        input logic [2:0] bc);
        logic e;
        case (bc)
            3'b000:  e = 1'b0;
            3'b001:  e = off[0];
            3'b010:  e = (off != 2'b00);
            3'b100:  e = we;
            3'b101:  e = we | off[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] word,
                                                          input logic [1:0] off,
                                                          input logic [2:0] bc);
        logic [DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0] res;
        sh = word >> {off, 3'b000};
        case (bc)
            3'b000:  res = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
            3'b001:  res = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
            3'b100:  res = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
            3'b101:  res = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] off, input logic [2:0] bc);
        logic [3:0] be;
        case (bc[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // With LATENCY == 1 the commit edge is also the acceptance edge,
    // so the commit path must see the live request rather than the captured copy.
    logic                  cur_we;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [2:0]            cur_bc;
    logic                  cur_err;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [3:0]            wr_be;

    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_bc    = bytecontrol;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_bc    = bc_q;
        end
        cur_err = access_err(cur_we, cur_addr[1:0], cur_bc);
        rd_word = {mem_q[{cur_addr[ADDR_WIDTH-1:2], 2'd3}],
                   mem_q[{cur_addr[ADDR_WIDTH-1:2], 2'd2}],
                   mem_q[{cur_addr[ADDR_WIDTH-1:2], 2'd1}],
                   mem_q[{cur_addr[ADDR_WIDTH-1:2], 2'd0}]};
        wr_word = cur_wdata << {cur_addr[1:0], 3'b000};
        wr_be   = lane_enables(cur_addr[1:0], cur_bc);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        we_d    = capture ? req_we      : we_q;
        addr_d  = capture ? req_addr    : addr_q;
        wdata_d = capture ? req_wdata   : wdata_q;
        bc_d    = capture ? bytecontrol : bc_q;

        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            err_d   = cur_err;
            rdata_d = (cur_we || cur_err) ? '0 : load_extend(rd_word, cur_addr[1:0], cur_bc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            bc_q    <= 3'b000;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bc_q    <= bc_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // The RAM is never cleared; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (commit && !rst && cur_we && !cur_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_q[{cur_addr[ADDR_WIDTH-1:2], 2'(i)}] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances with LATENCY 1, 2 and 3.
// The bench holds the expected values in a vector table and adds hand-written sequences for backpressure, resets and throughput.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst  [3];
    logic        rv   [3];
    logic        rdy  [3];
    logic        we   [3];
    logic [11:0] addr [3];
    logic [31:0] wd   [3];
    logic [2:0]  bc   [3];
    logic        respv[3];
    logic        respr[3];
    logic [31:0] rdata[3];
    logic        err  [3];

    int checks = 0;
    int errors = 0;
    int lat_of [3] = '{1, 2, 3};

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(we[0]),
        .req_addr(addr[0]), .req_wdata(wd[0]), .bytecontrol(bc[0]), .resp_valid(respv[0]),
        .resp_ready(respr[0]), .resp_rdata(rdata[0]), .resp_err(err[0]));
    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(we[1]),
        .req_addr(addr[1]), .req_wdata(wd[1]), .bytecontrol(bc[1]), .resp_valid(respv[1]),
        .resp_ready(respr[1]), .resp_rdata(rdata[1]), .resp_err(err[1]));
    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst[2]), .req_valid(rv[2]), .req_ready(rdy[2]), .req_we(we[2]),
        .req_addr(addr[2]), .req_wdata(wd[2]), .bytecontrol(bc[2]), .resp_valid(respv[2]),
        .resp_ready(respr[2]), .resp_rdata(rdata[2]), .resp_err(err[2]));

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [2:0]  bc;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic w, input logic [11:0] a,
                         input logic [31:0] data, input logic [2:0] b);
        rv[d]   = 1'b1;
        we[d]   = w;
        addr[d] = a;
        wd[d]   = data;
        bc[d]   = b;
    endtask

    // Waits (bounded) for resp_valid; n counts cycles after the acceptance edge.
    task automatic wait_resp(input int d, input string name);
        int n;
        n = 1;
        while (!respv[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, n, lat_of[d]);
    endtask

    task automatic do_req(input int d, input logic w, input logic [11:0] a,
                          input logic [31:0] data, input logic [2:0] b,
                          input logic [31:0] exp_rd, input logic exp_err, input string name);
        @(negedge clk);
        check({name, "_req_ready"}, 32'(rdy[d]), 32'd1);
        drive(d, w, a, data, b);
        @(posedge clk);
        @(negedge clk);
        rv[d] = 1'b0;
        wait_resp(d, name);
        check({name, "_rdata"}, rdata[d], exp_rd);
        check({name, "_err"}, 32'(err[d]), 32'(exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int bad;
        vecs[0]  = '{1'b1, 12'h000, 32'h11223344, 3'b010, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 12'h004, 32'h00000000, 3'b010, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b1, 12'h010, 32'hDEADBEEF, 3'b010, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 12'h010, 32'h00000000, 3'b010, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b1, 12'h005, 32'h000000AB, 3'b000, 32'h00000000, 1'b0};
        vecs[5]  = '{1'b0, 12'h005, 32'h00000000, 3'b000, 32'hFFFFFFAB, 1'b0};
        vecs[6]  = '{1'b0, 12'h005, 32'h00000000, 3'b100, 32'h000000AB, 1'b0};
        vecs[7]  = '{1'b0, 12'h004, 32'h00000000, 3'b010, 32'h0000AB00, 1'b0};
        vecs[8]  = '{1'b1, 12'h003, 32'h00001234, 3'b001, 32'h00000000, 1'b1};
        vecs[9]  = '{1'b0, 12'h000, 32'h00000000, 3'b010, 32'h11223344, 1'b0};
        vecs[10] = '{1'b0, 12'h004, 32'h00000000, 3'b010, 32'h0000AB00, 1'b0};
        vecs[11] = '{1'b0, 12'h000, 32'h00000000, 3'b011, 32'h00000000, 1'b1};
        vecs[12] = '{1'b0, 12'h002, 32'h00000000, 3'b010, 32'h00000000, 1'b1};
        vecs[13] = '{1'b0, 12'h001, 32'h00000000, 3'b001, 32'h00000000, 1'b1};
        vecs[14] = '{1'b1, 12'h000, 32'h000000FF, 3'b100, 32'h00000000, 1'b1};
        vecs[15] = '{1'b1, 12'h000, 32'h0000FFFF, 3'b101, 32'h00000000, 1'b1};
        vecs[16] = '{1'b0, 12'h000, 32'h00000000, 3'b110, 32'h00000000, 1'b1};
        vecs[17] = '{1'b0, 12'h000, 32'h00000000, 3'b111, 32'h00000000, 1'b1};
        vecs[18] = '{1'b0, 12'h000, 32'h00000000, 3'b010, 32'h11223344, 1'b0};
        vecs[19] = '{1'b1, 12'h002, 32'hFFFF8001, 3'b001, 32'h00000000, 1'b0};
        vecs[20] = '{1'b0, 12'h002, 32'h00000000, 3'b101, 32'h00008001, 1'b0};
        vecs[21] = '{1'b0, 12'h000, 32'h00000000, 3'b001, 32'h00003344, 1'b0};
        vecs[22] = '{1'b0, 12'h003, 32'h00000000, 3'b000, 32'hFFFFFF80, 1'b0};
        vecs[23] = '{1'b0, 12'h002, 32'h00000000, 3'b100, 32'h00000001, 1'b0};
        vecs[24] = '{1'b1, 12'h013, 32'h12345677, 3'b000, 32'h00000000, 1'b0};
        vecs[25] = '{1'b0, 12'h010, 32'h00000000, 3'b010, 32'h77ADBEEF, 1'b0};
        vecs[26] = '{1'b0, 12'h011, 32'h00000000, 3'b000, 32'hFFFFFFBE, 1'b0};

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; rv[d] = 1'b0; we[d] = 1'b0; addr[d] = '0;
            wd[d] = '0; bc[d] = 3'b000; respr[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_req_ready_%0d", d), 32'(rdy[d]), 32'd1);
            check($sformatf("reset_resp_valid_%0d", d), 32'(respv[d]), 32'd0);
            check($sformatf("reset_rdata_%0d", d), rdata[d], 32'd0);
            check($sformatf("reset_err_%0d", d), 32'(err[d]), 32'd0);
        end

        for (int i = 0; i < 27; i++) begin
            do_req(1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].bc,
                   vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Backpressure: LH 0x002 held 4 extra cycles while a store is presented and must be ignored
        @(negedge clk);
        respr[1] = 1'b0;
        drive(1, 1'b0, 12'h002, 32'h0, 3'b001);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b1, 12'h000, 32'hBAD0BAD0, 3'b010);
        wait_resp(1, "bp");
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_valid_%0d", k), 32'(respv[1]), 32'd1);
            check($sformatf("bp_rdata_%0d", k), rdata[1], 32'hFFFF8001);
            check($sformatf("bp_err_%0d", k), 32'(err[1]), 32'd0);
            check($sformatf("bp_req_ready_%0d", k), 32'(rdy[1]), 32'd0);
            if (k < 4) @(negedge clk);
        end
        respr[1] = 1'b1;
        rv[1] = 1'b0;
        @(negedge clk);
        check("bp_release_valid", 32'(respv[1]), 32'd0);
        check("bp_release_ready", 32'(rdy[1]), 32'd1);
        do_req(1, 1'b0, 12'h000, 32'h0, 3'b010, 32'h80013344, 1'b0, "bp_after");

        // LATENCY=3: reset in the first WAIT cycle drops the store
        do_req(2, 1'b1, 12'h020, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, "l3_pre");
        @(negedge clk);
        drive(2, 1'b1, 12'h020, 32'h00000055, 3'b010);
        @(posedge clk);
        @(negedge clk);
        rv[2] = 1'b0;
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        check("l3_rst_ready", 32'(rdy[2]), 32'd1);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (respv[2]) bad++;
            @(negedge clk);
        end
        check("l3_rst_no_resp", bad, 0);
        do_req(2, 1'b0, 12'h020, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, "l3_dropped");

        // LATENCY=3: reset while in RESP keeps the committed write
        @(negedge clk);
        respr[2] = 1'b0;
        drive(2, 1'b1, 12'h024, 32'h600DF00D, 3'b010);
        @(posedge clk);
        @(negedge clk);
        rv[2] = 1'b0;
        wait_resp(2, "l3_resp_rst");
        rst[2] = 1'b1;
        respr[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        check("l3_resp_rst_valid", 32'(respv[2]), 32'd0);
        check("l3_resp_rst_rdata", rdata[2], 32'd0);
        do_req(2, 1'b0, 12'h024, 32'h0, 3'b010, 32'h600DF00D, 1'b0, "l3_kept");

        // LATENCY=1: req_valid held high, one acceptance every other cycle
        acc = 0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            drive(0, 1'b1, 12'(12'h040 + acc * 4), 32'(32'hA0 + acc), 3'b010);
            check($sformatf("l1_ready_%0d", k), 32'(rdy[0]), 32'((k % 2) == 0));
            check($sformatf("l1_valid_%0d", k), 32'(respv[0]), 32'((k % 2) == 1));
            if (rdy[0]) acc++;
            @(negedge clk);
        end
        rv[0] = 1'b0;
        check("l1_accepts", acc, 4);
        for (int j = 0; j < 4; j++) begin
            do_req(0, 1'b0, 12'(12'h040 + j * 4), 32'h0, 3'b010, 32'(32'hA0 + j), 1'b0,
                   $sformatf("l1_load%0d", j));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
